// File: rtl/ofdm_rx_byte_packer_pkg.sv
// Shared types and constants for the OFDM RX byte packer.
package ofdm_rx_pkg;

  typedef logic [1:0] pair_t;
  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } packer_state_t;

  localparam int pairs_per_byte_c = 4;

endpackage

// File: rtl/ofdm_rx_byte_packer_if.sv
// Bit-pair input stream and valid/ready byte output of the packer.
interface ofdm_rx_byte_packer_if;
  import ofdm_rx_pkg::*;

  pair_t rx_rcv_data;
  logic  rx_rcv_data_valid;
  logic  rx_rcv_data_start;
  byte_t byte_data;
  logic  byte_valid;
  logic  byte_ready;

  modport master (
    output rx_rcv_data,
    output rx_rcv_data_valid,
    output rx_rcv_data_start,
    output byte_ready,
    input  byte_data,
    input  byte_valid
  );

  modport slave (
    input  rx_rcv_data,
    input  rx_rcv_data_valid,
    input  rx_rcv_data_start,
    input  byte_ready,
    output byte_data,
    output byte_valid
  );

endinterface

// File: rtl/ofdm_rx_byte_packer_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_byte_fifo
  import ofdm_rx_pkg::*;
#(
  parameter int depth_c = 4
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  clear,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head,
  output logic  full,
  output logic  empty
);

  localparam int aw_c = $clog2(depth_c);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [aw_c:0] wr_ptr;
  logic [aw_c:0] rd_ptr;
  byte_t         mem [depth_c];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[aw_c] != rd_ptr[aw_c]) &&
                   (wr_ptr[aw_c-1:0] == rd_ptr[aw_c-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[aw_c-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[aw_c-1:0]] <= push_data;
  end

endmodule

// File: rtl/ofdm_rx_byte_packer.sv
// Packs QPSK bit pairs MSB-first into bytes per OFDM symbol, buffers them in
// a small FIFO and reports symbol completion, truncation and overflow.
module ofdm_rx_byte_packer
  import ofdm_rx_pkg::*;
#(
  parameter int carrier_count_c      = 32,
  parameter int rcv_data_width_c     = 2,
  parameter int fifo_depth_c         = 4,
  parameter int symbol_count_width_c = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rstn,
  input  logic                            sys_init,
  ofdm_rx_byte_packer_if.slave            bus,
  output logic                            symbol_done,
  output logic [symbol_count_width_c-1:0] symbol_count,
  output logic                            err_short_symbol,
  output logic                            err_overflow
);

  localparam int idx_w_c = $clog2(carrier_count_c + 1);
  localparam logic [idx_w_c-1:0] last_idx_c  = idx_w_c'(carrier_count_c);
  localparam logic [idx_w_c-1:0] per_byte_c  = idx_w_c'(pairs_per_byte_c);

  packer_state_t      state;
  packer_state_t      next_state;
  logic [idx_w_c-1:0] pair_idx;
  logic [idx_w_c-1:0] pair_idx_inc;
  byte_t              shift_reg;
  byte_t              next_byte;
  logic [1:0]         slot;
  logic [2:0]         slot_lsb;
  logic               clear;
  logic               accept;
  logic               restart;
  logic               advance;
  logic               push;
  logic               sym_complete;
  logic               short_hit;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  byte_t              fifo_head;

  assign clear        = !sys_rstn || sys_init;
  assign accept       = bus.rx_rcv_data_valid;
  assign pair_idx_inc = pair_idx + 1'b1;
  assign slot         = 2'(pair_idx % per_byte_c);
  assign slot_lsb     = 3'((pairs_per_byte_c - 1 - int'(slot)) * rcv_data_width_c);

  always_ff @(posedge sys_clk) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept && bus.rx_rcv_data_start) next_state = COLLECT;
      COLLECT: if (sym_complete) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Slot 0 of each byte starts from a clean byte so stale pairs never leak.
  always_comb begin
    restart      = 1'b0;
    advance      = 1'b0;
    push         = 1'b0;
    sym_complete = 1'b0;
    short_hit    = 1'b0;
    next_byte    = (slot == 2'd0) ? '0 : shift_reg;
    next_byte[slot_lsb +: rcv_data_width_c] = bus.rx_rcv_data;
    unique case (state)
      IDLE: begin
        if (accept && bus.rx_rcv_data_start) restart = 1'b1;
      end
      COLLECT: begin
        if (accept && bus.rx_rcv_data_start) begin
          restart   = 1'b1;
          short_hit = 1'b1;
        end else if (accept) begin
          advance = 1'b1;
          if ((pair_idx_inc % per_byte_c) == '0) push = 1'b1;
          if (pair_idx_inc == last_idx_c) sym_complete = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (clear) begin
      shift_reg        <= '0;
      pair_idx         <= '0;
      symbol_done      <= 1'b0;
      symbol_count     <= '0;
      err_short_symbol <= 1'b0;
      err_overflow     <= 1'b0;
    end else begin
      if (restart) begin
        shift_reg <= {bus.rx_rcv_data, 6'b0};
        pair_idx  <= idx_w_c'(1);
      end else if (advance) begin
        shift_reg <= next_byte;
        pair_idx  <= sym_complete ? '0 : pair_idx_inc;
      end
      symbol_done <= sym_complete;
      if (sym_complete) symbol_count <= symbol_count + 1'b1;
      if (short_hit) err_short_symbol <= 1'b1;
      if (push && fifo_full && !bus.byte_ready) err_overflow <= 1'b1;
    end
  end

  assign fifo_pop       = !fifo_empty && bus.byte_ready;
  assign bus.byte_valid = !fifo_empty;
  assign bus.byte_data  = fifo_empty ? '0 : fifo_head;

  sync_byte_fifo #(
    .depth_c (fifo_depth_c)
  ) u_fifo (
    .clk       (sys_clk),
    .rstn      (sys_rstn),
    .clear     (sys_init),
    .push      (push),
    .push_data (next_byte),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
